seq_chunk_adder: RTL and testbench

//  Parametrised multi-cycle ripple-carry adder/subtractor; processes CHUNK bits per clock.
//  A registered carry links the chunks, giving WIDTH-bit add/sub on a small chunk-wide adder.

---
 rtl/adder_pkg.sv | 14 +
 rtl/chunk_rca.sv | 24 ++
 rtl/seq_chunk_adder.sv | 108 ++++++++++
 tb/tb_seq_chunk_adder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the chunked sequential adder.
package adder_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
      return width / chunk;
   endfunction

   function automatic bit width_ok(input int unsigned width, input int unsigned chunk);
      return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/chunk_rca.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module chunk_rca #(
   parameter int unsigned CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   logic carry;

   always_comb begin
      sum   = '0;
      carry = cin;
      for (int i = 0; i < int'(CHUNK); i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-wide slice per clock, carry held in a register.
module seq_chunk_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NChunk   = nchunk(WIDTH, CHUNK);
   localparam int unsigned IdxWidth = (NChunk > 1) ? $clog2(NChunk) : 1;
   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NChunk - 1);

   if (!width_ok(WIDTH, CHUNK)) begin : gen_width_err
      $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   state_e              state_q;
   logic [WIDTH-1:0]    a_q, b_q, s_q;
   logic [IdxWidth-1:0] idx_q;
   logic                carry_q, cout_q, ovf_q, out_valid_q;

   logic [31:0]         base;
   logic [CHUNK-1:0]    chunk_a, chunk_b, chunk_sum;
   logic                chunk_cout, last;

   assign base    = 32'(idx_q) * CHUNK;
   assign chunk_a = a_q[base +: CHUNK];
   assign chunk_b = b_q[base +: CHUNK];
   assign last    = (idx_q == LastIdx);

   chunk_rca #(
      .CHUNK (CHUNK)
   ) u_rca (
      .a    (chunk_a),
      .b    (chunk_b),
      .cin  (carry_q),
      .sum  (chunk_sum),
      .cout (chunk_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         a_q         <= '0;
         b_q         <= '0;
         s_q         <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  // Subtraction is a + ~b + ~borrow.
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  carry_q <= cin ^ sub;
                  idx_q   <= '0;
                  state_q <= StRun;
               end
            end
            StRun: begin
               s_q[base +: CHUNK] <= chunk_sum;
               carry_q            <= chunk_cout;
               if (last) begin
                  cout_q      <= chunk_cout;
                  ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                 (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end else begin
                  idx_q <= idx_q + IdxWidth'(1);
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready  = (state_q == StIdle) && !rst;
   assign out_valid = out_valid_q;
   assign s         = s_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder: random and directed operands against an arithmetic model.
module tb_seq_chunk_adder;

   localparam int NCH    = 8;
   localparam int PERIOD = 10;

   typedef struct {
      logic [31:0] s;
      logic        cout;
      logic        ovf;
      time         t_acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
   logic        out_valid, out_ready = 1'b1, cout, ovf;
   logic [31:0] a = '0, b = '0, s;

   logic        in_valid8 = 1'b0, in_ready8, cin8 = 1'b0, sub8 = 1'b0;
   logic        out_valid8, out_ready8 = 1'b1, cout8, ovf8;
   logic [7:0]  a8 = '0, b8 = '0, s8;

   int   checks = 0;
   int   errors = 0;
   int   ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
   exp_t q[$];

   seq_chunk_adder #(.WIDTH(32), .CHUNK(4)) u_dut (
      .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
      .a (a), .b (b), .cin (cin), .sub (sub), .out_valid (out_valid),
      .out_ready (out_ready), .s (s), .cout (cout), .ovf (ovf)
   );

   seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
      .clk (clk), .rst (rst), .in_valid (in_valid8), .in_ready (in_ready8),
      .a (a8), .b (b8), .cin (cin8), .sub (sub8), .out_valid (out_valid8),
      .out_ready (out_ready8), .s (s8), .cout (cout8), .ovf (ovf8)
   );

   initial forever #(PERIOD / 2) clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: exact integer arithmetic, overflow as a signed range test.
   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic c,
                                  input logic sb);
      exp_t   r;
      longint ux, uy, uc, u, sx, sy, sr;
      ux = {32'b0, x};
      uy = {32'b0, y};
      uc = {63'b0, c};
      sx = $signed(x);
      sy = $signed(y);
      if (!sb) begin
         u      = ux + uy + uc;
         r.cout = u[32];
         sr     = sx + sy + uc;
      end else begin
         u      = ux - uy - uc;
         r.cout = (ux >= uy + uc);
         sr     = sx - sy - uc;
      end
      r.s     = u[31:0];
      r.ovf   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      r.t_acc = 0;
      return r;
   endfunction

   task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c,
                       input logic sb);
      exp_t e;
      bit   got = 1'b0;
      a = x; b = y; cin = c; sub = sb; in_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      chk("accept_timeout", 64'(got), 64'd1);
      if (got) begin
         @(posedge clk);
         e       = model(x, y, c, sb);
         e.t_acc = $time;
         q.push_back(e);
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (q.size() == 0 && in_ready) begin
            done = 1'b1;
            break;
         end
      end
      chk("drain_timeout", 64'(done), 64'd1);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: checks latency on the rising out_valid, the result on every presented cycle.
   initial begin
      logic ov_prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
               e = q[0];
               if (!ov_prev)
                  chk("latency", 64'($time - e.t_acc), 64'(NCH * PERIOD + PERIOD / 2));
               chk("s", 64'(s), 64'(e.s));
               chk("cout", 64'(cout), 64'(e.cout));
               chk("ovf", 64'(ovf), 64'(e.ovf));
               chk("in_ready_busy", 64'(in_ready), 64'd0);
               if (out_ready) void'(q.pop_front());
            end
         end
         ov_prev = (out_valid === 1'b1);
      end
   end

   initial begin
      bit seen;
      // Reset state
      repeat (2) @(negedge clk);
      chk("in_ready_in_rst", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_s", 64'(s), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Directed arithmetic cases
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
      send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);
      send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
      drain();

      // Stall in DONE; operands offered meanwhile must be ignored
      ready_mode = 2;
      send(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0);
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk("stall_reach_done", 64'(seen), 64'd1);
      @(posedge clk);
      #1 a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 ready_mode = 0;
      drain();
      send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
      drain();

      // Reset while in RUN with idx=3 aborts the operation
      a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("abort_in_ready_in_rst", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_s", 64'(s), 64'd0);
      chk("abort_cout", 64'(cout), 64'd0);
      chk("abort_ovf", 64'(ovf), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
      drain();

      // Randomized traffic with random back-pressure
      ready_mode = 1;
      for (int i = 0; i < 30; i++)
         send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      ready_mode = 0;
      drain();
      chk("queue_empty", 64'(q.size()), 64'd0);

      // Single-chunk configuration
      a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
      @(negedge clk);
      chk("w8_in_ready", 64'(in_ready8), 64'd1);
      @(posedge clk);
      #1 in_valid8 = 1'b0;
      @(negedge clk);
      chk("w8_run_out_valid", 64'(out_valid8), 64'd0);
      @(negedge clk);
      chk("w8_out_valid", 64'(out_valid8), 64'd1);
      chk("w8_s", 64'(s8), 64'h00);
      chk("w8_cout", 64'(cout8), 64'd1);
      chk("w8_ovf", 64'(ovf8), 64'd1);
      @(negedge clk);
      chk("w8_out_valid_drop", 64'(out_valid8), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #(PERIOD * 20000);
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
